// File: rtl/rv32_pkg.sv
// Shared types for the RV32 memory-port arbiter: access tags, tie-break
// state and the supported read-latency ceiling.
package rv32_pkg;

  localparam int MEM_LAT_MAX = 4;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_DRD  = 2'd2,
    TAG_DWR  = 2'd3
  } mem_tag_t;

  typedef enum logic {
    WIN_IF = 1'b0,
    WIN_D  = 1'b1
  } arb_win_t;

  function automatic mem_tag_t data_tag(input logic we);
    return we ? TAG_DWR : TAG_DRD;
  endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// Delay line carrying one access tag per cycle so that each response can be
// matched to its requester exactly MEM_LAT cycles after the grant.
module mem_tag_pipe
  import rv32_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  mem_tag_t tag_in,
  output mem_tag_t tag_out
);

  mem_tag_t stage [MEM_LAT];

  // Reset flushes every in-flight tag so stale reads never surface.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        stage[i] <= TAG_NONE;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < MEM_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[MEM_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and the
// load/store unit, alternating on contention and routing tagged responses.
module mem_port_arbiter
  import rv32_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_win_t last_win;
  arb_win_t last_win_next;
  logic     grant_if;
  logic     grant_d;
  mem_tag_t tag_issue;
  mem_tag_t tag_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_win <= WIN_IF;
    end else begin
      last_win <= last_win_next;
    end
  end

  // Tie-break only moves on contended cycles; a lone requester always wins.
  always_comb begin
    grant_if      = 1'b0;
    grant_d       = 1'b0;
    last_win_next = last_win;
    if (!rst) begin
      if (if_req && d_req) begin
        if (last_win == WIN_IF) begin
          grant_d       = 1'b1;
          last_win_next = WIN_D;
        end else begin
          grant_if      = 1'b1;
          last_win_next = WIN_IF;
        end
      end else if (if_req) begin
        grant_if = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  assign if_gnt = grant_if;
  assign d_gnt  = grant_d;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    tag_issue = TAG_NONE;
    if (grant_if) begin
      mem_en    = 1'b1;
      mem_be    = 4'hF;
      mem_addr  = if_addr;
      tag_issue = TAG_IF;
    end else if (grant_d) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      tag_issue = data_tag(d_we);
    end
  end

  mem_tag_pipe #(
    .MEM_LAT (MEM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_issue),
    .tag_out (tag_done)
  );

  // Responses are masked during reset so nothing leaks out while flushing.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    if (!rst) begin
      case (tag_done)
        TAG_IF: begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
        TAG_DRD: begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end
        TAG_DWR: begin
          d_rvalid = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: three arbiters (latency 1..3) share one stimulus
// stream and a behavioural memory; a transaction-level model predicts outputs.
module tb_mem_port_arbiter;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [3:0]  d_be = 4'h0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        env_clear = 1'b1;

  logic        if_gnt_o    [3];
  logic        if_rvalid_o [3];
  logic [31:0] if_rdata_o  [3];
  logic        d_gnt_o     [3];
  logic        d_rvalid_o  [3];
  logic [31:0] d_rdata_o   [3];
  logic        mem_en_o    [3];
  logic        mem_we_o    [3];
  logic [3:0]  mem_be_o    [3];
  logic [31:0] mem_addr_o  [3];
  logic [31:0] mem_wdata_o [3];
  logic [31:0] rd_pipe     [4];

  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];

  resp_t q0[$];
  resp_t q1[$];
  resp_t q2[$];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic prefer_d = 1'b1;
  logic last_e_if;
  logic last_e_d;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .MEM_LAT (g + 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt_o[g]),
      .if_rvalid (if_rvalid_o[g]),
      .if_rdata  (if_rdata_o[g]),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_be      (d_be),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt_o[g]),
      .d_rvalid  (d_rvalid_o[g]),
      .d_rdata   (d_rdata_o[g]),
      .mem_en    (mem_en_o[g]),
      .mem_we    (mem_we_o[g]),
      .mem_be    (mem_be_o[g]),
      .mem_addr  (mem_addr_o[g]),
      .mem_wdata (mem_wdata_o[g]),
      .mem_rdata (rd_pipe[g])
    );
  end

  function automatic logic [31:0] init_word(input int i);
    if (i == 1) return 32'h00100093;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // Memory macro: writes land on the strobe edge, reads come back after the
  // per-instance latency; idle slots return noise.
  always @(posedge clk) begin
    if (env_clear) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
    end else if (mem_en_o[0] && mem_we_o[0]) begin
      env_mem[mem_addr_o[0][9:2]] <= merge(env_mem[mem_addr_o[0][9:2]], mem_wdata_o[0],
                                           mem_be_o[0]);
    end
    rd_pipe[0] <= (mem_en_o[0] && !mem_we_o[0]) ? env_mem[mem_addr_o[0][9:2]] : $urandom;
    for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_resp(input int k, input resp_t r);
    case (k)
      0: q0.push_back(r);
      1: q1.push_back(r);
      default: q2.push_back(r);
    endcase
  endtask

  // One clock cycle: drive inputs, check every instance, advance the model.
  task automatic applyStimulus(input logic r, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dwe, input logic [3:0] dbe,
                               input logic [31:0] da, input logic [31:0] dwd);
    logic  e_if, e_d, e_en, e_we;
    logic [3:0] e_be;
    logic [31:0] e_addr, e_wd;
    resp_t exp_r [3];
    int    kd;
    @(negedge clk);
    rst = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
    #1;
    e_if = 1'b0;
    e_d  = 1'b0;
    if (!r) begin
      if (ir && dr) begin
        if (prefer_d) e_d = 1'b1; else e_if = 1'b1;
      end else if (ir) e_if = 1'b1;
      else if (dr) e_d = 1'b1;
    end
    e_en = e_if || e_d;
    e_we = e_d && dwe;
    e_be = e_if ? 4'hF : (e_d ? dbe : 4'h0);
    e_addr = e_if ? ia : (e_d ? da : 32'h0);
    e_wd = e_d ? dwd : 32'h0;
    for (int k = 0; k < 3; k++) exp_r[k] = '{due: 0, kind: 0, data: 32'h0};
    if (q0.size() > 0 && q0[0].due == cyc) exp_r[0] = q0.pop_front();
    if (q1.size() > 0 && q1[0].due == cyc) exp_r[1] = q1.pop_front();
    if (q2.size() > 0 && q2[0].due == cyc) exp_r[2] = q2.pop_front();
    for (int k = 0; k < 3; k++) begin
      kd = r ? 0 : exp_r[k].kind;
      checkOutput($sformatf("L%0d if_gnt", k+1), 32'(if_gnt_o[k]), 32'(e_if));
      checkOutput($sformatf("L%0d d_gnt", k+1), 32'(d_gnt_o[k]), 32'(e_d));
      checkOutput($sformatf("L%0d mem_en", k+1), 32'(mem_en_o[k]), 32'(e_en));
      checkOutput($sformatf("L%0d mem_we", k+1), 32'(mem_we_o[k]), 32'(e_we));
      checkOutput($sformatf("L%0d mem_be", k+1), 32'(mem_be_o[k]), 32'(e_be));
      checkOutput($sformatf("L%0d mem_addr", k+1), mem_addr_o[k], e_addr);
      checkOutput($sformatf("L%0d mem_wdata", k+1), mem_wdata_o[k], e_wd);
      checkOutput($sformatf("L%0d if_rvalid", k+1), 32'(if_rvalid_o[k]), 32'(kd == 1));
      checkOutput($sformatf("L%0d if_rdata", k+1), if_rdata_o[k],
                  (kd == 1) ? exp_r[k].data : 32'h0);
      checkOutput($sformatf("L%0d d_rvalid", k+1), 32'(d_rvalid_o[k]),
                  32'(kd == 2 || kd == 3));
      checkOutput($sformatf("L%0d d_rdata", k+1), d_rdata_o[k],
                  (kd == 2) ? exp_r[k].data : 32'h0);
    end
    if (r) begin
      q0.delete(); q1.delete(); q2.delete();
      prefer_d = 1'b1;
    end else begin
      if (ir && dr) prefer_d = e_if;
      for (int k = 0; k < 3; k++) begin
        if (e_if) push_resp(k, '{due: cyc + k + 1, kind: 1, data: ref_mem[ia[9:2]]});
        else if (e_d && !dwe) push_resp(k, '{due: cyc + k + 1, kind: 2, data: ref_mem[da[9:2]]});
        else if (e_d) push_resp(k, '{due: cyc + k + 1, kind: 3, data: 32'h0});
      end
      if (e_d && dwe) ref_mem[da[9:2]] = merge(ref_mem[da[9:2]], dwd, dbe);
    end
    last_e_if = e_if;
    last_e_d  = e_d;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic ip, dp, dwe_r;
    logic [31:0] ia_r, da_r, dwd_r;
    logic [3:0]  dbe_r;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    do_reset(3);
    env_clear = 1'b0;
    do_reset(1);

    // Fetch only: response one cycle later on the latency-1 instance.
    applyStimulus(0, 1, 32'h4, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("plan fetch rdata", if_rdata_o[0], 32'h00100093);
    idle(3);

    // Contention right after reset: D, IF, D, IF.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 32'h40 + 32'(4*i), 1, 0, 4'hF, 32'h80 + 32'(4*i), 0);
      checkOutput("plan tie d_gnt", 32'(last_e_d), 32'(i % 2 == 0));
    end
    idle(4);

    // Store then load to the same word; latency-2 instance.
    applyStimulus(0, 0, 0, 1, 1, 4'hF, 32'h100, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 1, 0, 4'hF, 32'h100, 0);
    idle(1);
    checkOutput("plan store ack", 32'(d_rvalid_o[1]), 32'h1);
    idle(1);
    checkOutput("plan load data", d_rdata_o[1], 32'hDEADBEEF);
    idle(3);

    // Byte store to lane 1, then read back.
    applyStimulus(0, 0, 0, 1, 1, 4'b0010, 32'h200, 32'h0000AB00);
    checkOutput("plan byte mem_be", 32'(mem_be_o[0]), 32'h2);
    applyStimulus(0, 0, 0, 1, 0, 4'hF, 32'h200, 0);
    idle(1);
    checkOutput("plan byte lane", 32'(d_rdata_o[0][15:8]), 32'hAB);
    idle(3);

    // Reset while a fetch is in flight on the latency-3 instance.
    applyStimulus(0, 1, 32'h8, 0, 0, 0, 0, 0);
    do_reset(1);
    idle(5);

    idle(10);

    // Randomised traffic with hold-until-granted requesters.
    ip = 0; dp = 0; ia_r = 0; da_r = 0; dwd_r = 0; dbe_r = 0; dwe_r = 0;
    for (int n = 0; n < 800; n++) begin
      if (!ip && ($urandom % 3 != 0)) begin
        ip = 1; ia_r = $urandom & 32'h3FC;
      end
      if (!dp && ($urandom % 3 != 0)) begin
        dp = 1; da_r = $urandom & 32'h3FF; dwe_r = 1'($urandom);
        dbe_r = 4'($urandom); dwd_r = $urandom;
      end
      applyStimulus(($urandom % 97) == 0, ip, ia_r, dp, dwe_r, dbe_r, da_r, dwd_r);
      if (last_e_if) ip = 0;
      if (last_e_d) dp = 0;
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
